// File: rtl/pocket_pkg.sv
//==============================================================================
// Module  : pocket_pkg
// Brief   : Shared types and constants for the port sequencing logic.
// Revision: 1.0
//==============================================================================
`default_nettype none

package pocket_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      TURN   = 2'd1,
      ACCESS = 2'd2
   } port_seq_state_e;

   localparam logic PORT_DIR_READ  = 1'b0;
   localparam logic PORT_DIR_WRITE = 1'b1;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

`default_nettype wire

// File: rtl/port_sequencer_rr_arbiter2.sv
//==============================================================================
// Module  : rr_arbiter2
// Brief   : Two-way combinational round-robin arbiter; rr names the preferred index.
// Revision: 1.0
//==============================================================================
`default_nettype none

module rr_arbiter2 (
   input  logic [1:0] valid,
   input  logic       rr,
   output logic [1:0] grant_onehot,
   output logic       grant_idx
);

   always_comb begin
      grant_idx    = 1'b0;
      grant_onehot = 2'b00;
      if (valid == 2'b11) begin
         grant_idx = rr;
      end else begin
         grant_idx = valid[1];
      end
      if (valid != 2'b00) begin
         grant_onehot = grant_idx ? 2'b10 : 2'b01;
      end
   end

endmodule

`default_nettype wire

// File: rtl/port_sequencer.sv
//==============================================================================
// Module  : port_sequencer
// Brief   : Shares one bidirectional port between two requesters with turnaround.
// Revision: 1.0
//==============================================================================
`default_nettype none

module port_sequencer
   import pocket_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int TURNAROUND = 2,
   parameter int SETTLE     = 3
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [1:0]            req_valid,
   input  logic [1:0]            req_write,
   input  logic [1:0][WIDTH-1:0] req_wdata,
   output logic [1:0]            req_ready,
   output logic                  rsp_valid,
   output logic                  rsp_id,
   output logic [WIDTH-1:0]      rsp_rdata,
   output logic                  dir_to_port,
   output logic [WIDTH-1:0]      to_port,
   input  logic [WIDTH-1:0]      from_port
);

   localparam int c_cnt_w = $clog2(max2(TURNAROUND, SETTLE) + 1);
   localparam logic [c_cnt_w-1:0] c_turn_load   = c_cnt_w'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);
   localparam logic [c_cnt_w-1:0] c_settle_load = c_cnt_w'(SETTLE - 1);

   port_seq_state_e     r_state, w_state_nxt;
   logic [c_cnt_w-1:0]  r_cnt, w_cnt_nxt;
   logic                r_rr, r_last_dir, r_gid, r_dir;
   logic [WIDTH-1:0]    r_wdata, r_to_port, r_rsp_rdata;
   logic                r_rsp_valid, r_rsp_id;
   logic [1:0]          w_grant_onehot;
   logic                w_grant_idx, w_accept, w_enter_access, w_access_dir, w_read_done;
   logic [WIDTH-1:0]    w_access_data;

   rr_arbiter2 u_arb (
      .valid        (req_valid),
      .rr           (r_rr),
      .grant_onehot (w_grant_onehot),
      .grant_idx    (w_grant_idx)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // In IDLE the direction/data come straight from the winner so a no-turn accept enters ACCESS directly.
   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_accept       = 1'b0;
      w_enter_access = 1'b0;
      w_access_dir   = r_dir;
      w_access_data  = r_wdata;
      req_ready      = 2'b00;
      unique case (r_state)
         IDLE: begin
            req_ready     = w_grant_onehot;
            w_accept      = |req_valid;
            w_access_dir  = req_write[w_grant_idx];
            w_access_data = req_wdata[w_grant_idx];
            if (w_accept) begin
               if ((w_access_dir != r_last_dir) && (TURNAROUND > 0)) begin
                  w_state_nxt = TURN;
                  w_cnt_nxt   = c_turn_load;
               end else begin
                  w_state_nxt    = ACCESS;
                  w_cnt_nxt      = c_settle_load;
                  w_enter_access = 1'b1;
               end
            end
         end
         TURN: begin
            if (r_cnt == '0) begin
               w_state_nxt    = ACCESS;
               w_cnt_nxt      = c_settle_load;
               w_enter_access = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         ACCESS: begin
            if (r_cnt == '0) begin
               w_state_nxt = IDLE;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_read_done = (r_state == ACCESS) && (r_cnt == '0) && (r_dir == PORT_DIR_READ);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rr        <= 1'b0;
         r_gid       <= 1'b0;
         r_dir       <= PORT_DIR_READ;
         r_wdata     <= '0;
         r_last_dir  <= PORT_DIR_READ;
         r_to_port   <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         if (w_accept) begin
            r_gid   <= w_grant_idx;
            r_dir   <= w_access_dir;
            r_wdata <= w_access_data;
            r_rr    <= ~w_grant_idx;
         end
         if (w_enter_access) begin
            r_last_dir <= w_access_dir;
            if (w_access_dir == PORT_DIR_WRITE) begin
               r_to_port <= w_access_data;
            end
         end
         r_rsp_valid <= w_read_done;
         if (w_read_done) begin
            r_rsp_id    <= r_gid;
            r_rsp_rdata <= from_port;
         end
      end
   end

   // last_dir already equals the active direction during ACCESS, and doubles as the parked direction in IDLE.
   assign dir_to_port = (r_state == TURN) ? PORT_DIR_READ : r_last_dir;
   assign to_port     = r_to_port;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_id      = r_rsp_id;
   assign rsp_rdata   = r_rsp_rdata;

endmodule

`default_nettype wire

// File: tb/tb_port_sequencer.sv
//==============================================================================
// Module  : tb_port_sequencer
// Brief   : Self-checking bench: u0 (TURNAROUND=2, SETTLE=3), u1 (TURNAROUND=0, SETTLE=1).
// Revision: 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_port_sequencer;

   localparam int W = 8;

   logic               clk = 1'b0;
   logic               reset_n;
   logic [1:0]         req_valid   [2];
   logic [1:0]         req_write   [2];
   logic [1:0][W-1:0]  req_wdata   [2];
   logic [1:0]         req_ready   [2];
   logic               rsp_valid   [2];
   logic               rsp_id      [2];
   logic [W-1:0]       rsp_rdata   [2];
   logic               dir_to_port [2];
   logic [W-1:0]       to_port     [2];
   logic [W-1:0]       from_port   [2];

   always #10 clk = ~clk;

   port_sequencer #(.WIDTH(W), .TURNAROUND(2), .SETTLE(3)) u0 (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid[0]), .req_write(req_write[0]), .req_wdata(req_wdata[0]),
      .req_ready(req_ready[0]), .rsp_valid(rsp_valid[0]), .rsp_id(rsp_id[0]),
      .rsp_rdata(rsp_rdata[0]), .dir_to_port(dir_to_port[0]), .to_port(to_port[0]),
      .from_port(from_port[0])
   );

   port_sequencer #(.WIDTH(W), .TURNAROUND(0), .SETTLE(1)) u1 (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid[1]), .req_write(req_write[1]), .req_wdata(req_wdata[1]),
      .req_ready(req_ready[1]), .rsp_valid(rsp_valid[1]), .rsp_id(rsp_id[1]),
      .rsp_rdata(rsp_rdata[1]), .dir_to_port(dir_to_port[1]), .to_port(to_port[1]),
      .from_port(from_port[1])
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Timeline model: each accepted transfer is turned into the cycle numbers where it occupies the bus.
   typedef struct {
      int         idle_at;
      int         acc_start;
      int         rsp_at;
      bit         rr;
      bit         last_dir;
      bit         cur_dir;
      bit         rsp_id;
      logic [7:0] cur_data;
      logic [7:0] park;
      logic [7:0] rdata;
   } model_t;
   model_t m [2];

   typedef struct { logic [1:0] v; logic [1:0] exp_ready; } arb_vec_t;
   typedef struct { logic exp_dir; logic chk_to; logic [7:0] exp_to; } tl_vec_t;
   arb_vec_t arb_tab [4];
   tl_vec_t  wr_tab  [6];

   function automatic int t_of(input int i); return (i == 0) ? 2 : 0; endfunction
   function automatic int s_of(input int i); return (i == 0) ? 3 : 1; endfunction

   function automatic logic [1:0] arb(input logic [1:0] v, input bit rr);
      if (v == 2'b11) return rr ? 2'b10 : 2'b01;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m[i].idle_at  = 0;  m[i].acc_start = 0; m[i].rsp_at = -1;
         m[i].rr       = 0;  m[i].last_dir  = 0; m[i].cur_dir = 0; m[i].rsp_id = 0;
         m[i].cur_data = '0; m[i].park      = '0; m[i].rdata  = '0;
      end
   endtask

   task automatic model_check(input int i);
      bit idle;
      idle = (cyc >= m[i].idle_at);
      chk($sformatf("u%0d.req_ready", i), req_ready[i], idle ? arb(req_valid[i], m[i].rr) : 2'b00);
      if (idle) begin
         chk($sformatf("u%0d.dir_idle", i), dir_to_port[i], m[i].last_dir);
         chk($sformatf("u%0d.to_port_park", i), to_port[i], m[i].park);
      end else if (cyc >= m[i].acc_start) begin
         chk($sformatf("u%0d.dir_access", i), dir_to_port[i], m[i].cur_dir);
         if (m[i].cur_dir) chk($sformatf("u%0d.to_port_drive", i), to_port[i], m[i].cur_data);
      end else begin
         chk($sformatf("u%0d.dir_turn", i), dir_to_port[i], 0);
      end
      chk($sformatf("u%0d.rsp_valid", i), rsp_valid[i], (cyc == m[i].rsp_at));
      if (cyc == m[i].rsp_at) begin
         chk($sformatf("u%0d.rsp_id", i), rsp_id[i], m[i].rsp_id);
         chk($sformatf("u%0d.rsp_rdata", i), rsp_rdata[i], m[i].rdata);
      end
   endtask

   task automatic model_update(input int i);
      logic [1:0] oh;
      bit g, d;
      int t;
      if (cyc == m[i].rsp_at - 1) m[i].rdata = from_port[i];
      if (cyc >= m[i].idle_at && req_valid[i] != 2'b00) begin
         oh = arb(req_valid[i], m[i].rr);
         g  = oh[1];
         d  = req_write[i][g];
         t  = (d != m[i].last_dir) ? t_of(i) : 0;
         m[i].acc_start = cyc + 1 + t;
         m[i].idle_at   = cyc + s_of(i) + t + 1;
         m[i].cur_dir   = d;
         m[i].cur_data  = req_wdata[i][g];
         m[i].last_dir  = d;
         m[i].rr        = ~g;
         if (d) m[i].park = req_wdata[i][g];
         else begin
            m[i].rsp_at = m[i].idle_at;
            m[i].rsp_id = g;
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      for (int i = 0; i < 2; i++) model_check(i);
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         if (!reset_n) model_reset();
         else model_update(i);
      end
      cyc++;
      #1;
   endtask

   task automatic do_txn(input int i, input int id, input bit wr, input logic [7:0] d, output int acc);
      req_valid[i][id] = 1'b1;
      req_write[i][id] = wr;
      req_wdata[i][id] = d;
      acc = -1;
      for (int n = 0; n < 40; n++) begin
         #1;
         if (req_ready[i][id]) begin
            acc = cyc;
            tick();
            break;
         end
         tick();
      end
      req_valid[i][id] = 1'b0;
      if (acc < 0) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout: u%0d requester %0d got no req_ready, required within 40 cycles", i, id);
      end
   endtask

   initial begin
      int a, b, prev_acc;
      int gq[$], rq[$];
      logic prev_ready;
      bit drop;

      arb_tab[0] = '{2'b00, 2'b00};
      arb_tab[1] = '{2'b01, 2'b01};
      arb_tab[2] = '{2'b10, 2'b10};
      arb_tab[3] = '{2'b11, 2'b01};
      wr_tab[0]  = '{1'b0, 1'b0, 8'h00};
      wr_tab[1]  = '{1'b0, 1'b0, 8'h00};
      wr_tab[2]  = '{1'b1, 1'b1, 8'hA5};
      wr_tab[3]  = '{1'b1, 1'b1, 8'hA5};
      wr_tab[4]  = '{1'b1, 1'b1, 8'hA5};
      wr_tab[5]  = '{1'b1, 1'b1, 8'hA5};

      reset_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         req_valid[i] = '0; req_write[i] = '0; req_wdata[i] = '0; from_port[i] = '0;
      end
      model_reset();
      #5;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("u%0d.reset_rsp_valid", i), rsp_valid[i], 0);
         chk($sformatf("u%0d.reset_rsp_id", i), rsp_id[i], 0);
         chk($sformatf("u%0d.reset_rsp_rdata", i), rsp_rdata[i], 0);
         chk($sformatf("u%0d.reset_dir", i), dir_to_port[i], 0);
         chk($sformatf("u%0d.reset_to_port", i), to_port[i], 0);
      end
      tick();
      tick();
      reset_n = 1'b1;

      // Grant table in IDLE with rr at its reset value; no clock edge during the sweep.
      for (int k = 0; k < 4; k++) begin
         req_valid[0] = arb_tab[k].v;
         #1;
         chk($sformatf("arb_table[%0d]", k), req_ready[0], arb_tab[k].exp_ready);
      end
      req_valid[0] = 2'b00;

      // First write after reset: turn, then drive, then park driven.
      do_txn(0, 0, 1'b1, 8'hA5, a);
      for (int k = 0; k < 6; k++) begin
         chk($sformatf("first_write_dir[c%0d]", k + 1), dir_to_port[0], wr_tab[k].exp_dir);
         if (wr_tab[k].chk_to) chk($sformatf("first_write_to[c%0d]", k + 1), to_port[0], wr_tab[k].exp_to);
         tick();
      end

      do_txn(0, 0, 1'b1, 8'h11, a);
      do_txn(0, 0, 1'b1, 8'h22, b);
      chk("b2b_spacing", b - a, 4);
      chk("b2b_dir", dir_to_port[0], 1);
      chk("b2b_data", to_port[0], 8'h22);
      repeat (4) tick();

      from_port[0] = 8'h3C;
      do_txn(0, 1, 1'b0, 8'h00, a);
      for (int k = 1; k <= 6; k++) begin
         chk($sformatf("wr_rd_dir[c%0d]", k), dir_to_port[0], 0);
         chk($sformatf("wr_rd_rsp_valid[c%0d]", k), rsp_valid[0], (k == 6));
         if (k == 6) begin
            chk("wr_rd_rsp_id", rsp_id[0], 1);
            chk("wr_rd_rsp_rdata", rsp_rdata[0], 8'h3C);
         end
         tick();
      end

      // Contention: both requesters hold valid reads.
      req_write[0] = 2'b00;
      req_valid[0] = 2'b11;
      prev_ready   = 1'b0;
      drop         = 1'b0;
      for (int n = 0; n < 60 && !(gq.size() >= 4 && rq.size() >= 4); n++) begin
         #1;
         if (rsp_valid[0]) rq.push_back(int'(rsp_id[0]));
         if (req_ready[0] != 2'b00) begin
            chk("contention_ready_onehot", $countones(req_ready[0]), 1);
            chk("contention_ready_pulse", prev_ready, 0);
            gq.push_back(int'(req_ready[0][1]));
            if (gq.size() == 4) drop = 1'b1;
         end
         prev_ready = (req_ready[0] != 2'b00);
         tick();
         if (drop) req_valid[0] = 2'b00;
      end
      req_valid[0] = 2'b00;
      chk("contention_grants", gq.size(), 4);
      chk("contention_rsps", rq.size(), 4);
      for (int k = 0; k < gq.size(); k++) chk($sformatf("contention_grant[%0d]", k), gq[k], k % 2);
      for (int k = 0; k < rq.size(); k++) chk($sformatf("contention_rsp_id[%0d]", k), rq[k], k % 2);
      repeat (2) tick();

      // Reset during the second ACCESS cycle of a write.
      do_txn(0, 0, 1'b1, 8'h5A, a);
      repeat (3) tick();
      chk("mid_reset_dir_before", dir_to_port[0], 1);
      reset_n = 1'b0;
      model_reset();
      #1;
      chk("mid_reset_dir_async", dir_to_port[0], 0);
      tick();
      tick();
      reset_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         chk($sformatf("mid_reset_no_rsp[%0d]", k), rsp_valid[0], 0);
         tick();
      end
      do_txn(0, 0, 1'b1, 8'hC3, a);
      chk("post_reset_turn1", dir_to_port[0], 0);
      tick();
      chk("post_reset_turn2", dir_to_port[0], 0);
      tick();
      chk("post_reset_drive", dir_to_port[0], 1);
      chk("post_reset_data", to_port[0], 8'hC3);
      repeat (4) tick();

      // Corner instance: alternating write/read, one transfer every 2 cycles.
      prev_acc = -1;
      for (int k = 0; k < 6; k++) begin
         from_port[1] = 8'(k * 37 + 5);
         do_txn(1, 0, (k % 2 == 0), 8'(k + 8'h70), a);
         if (prev_acc >= 0) chk($sformatf("corner_spacing[%0d]", k), a - prev_acc, 2);
         prev_acc = a;
      end
      repeat (3) tick();

      // Random traffic on both instances against the timeline model.
      for (int n = 0; n < 1500; n++) begin
         for (int i = 0; i < 2; i++) begin
            req_valid[i] = 2'($urandom_range(0, 3));
            req_write[i] = 2'($urandom_range(0, 3));
            req_wdata[i] = 16'($urandom);
            from_port[i] = 8'($urandom);
         end
         tick();
      end
      for (int i = 0; i < 2; i++) req_valid[i] = 2'b00;
      repeat (10) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/port_sequencer.md
# port_sequencer

Sequences and shares one bidirectional port (the `port_if` tri-state bundle) between two requesters. Arbitrates round-robin, inserts bus turnaround cycles whenever the transfer direction changes, holds the drive or sample window for a fixed settle time, and returns read data. Sits between the core-side bus agents and the top-level `port_if` instance, driving its `dir_to_port` and `to_port` and observing `from_port`.

## Interface
- `WIDTH`, 8: port data width; matches `port_if` `hi_index - lo_index + 1`.
- `TURNAROUND`, 2: released-bus cycles inserted on a direction change. Legal range is 0 or more.
- `SETTLE`, 3: cycles a write is driven, or a read is waited, before completion. Legal range is 1 or more.
- `clk` in 1: single clock for all logic.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 2: per-requester transaction request.
- `req_write` in 2: per-requester direction. 1 means write to port, 0 means read.
- `req_wdata` in 2×WIDTH: per-requester write data.
- `req_ready` out 2: accept strobe. Transfer happens on `req_valid & req_ready`.
- `rsp_valid` out 1: one-cycle read-completion strobe.
- `rsp_id` out 1: requester index for the `rsp_valid` pulse.
- `rsp_rdata` out WIDTH: sampled read data, valid while `rsp_valid` is high.
- `dir_to_port` out 1: goes to `port_if.dir_to_port`. 1 means the block drives the pins.
- `to_port` out WIDTH: goes to `port_if.to_port`.
- `from_port` in WIDTH: from `port_if.from_port`.

## Operation
- FSM states: IDLE, TURN, ACCESS.
- **IDLE**
  - Grant goes to one requester with `req_valid` set, by round-robin. Pointer `rr` names the preferred index and resets to 0.
  - If only one requester is valid, it wins.
  - `req_ready[g]` is asserted combinationally in IDLE for the winner only.
  - On accept, latch `g`, `req_write[g]` and `req_wdata[g]`, then set `rr = ~g`.
  - If the latched direction differs from `last_dir` and `TURNAROUND > 0`, go to TURN. Otherwise go to ACCESS.
- **TURN**
  - `dir_to_port = 0`.
  - Counts TURNAROUND cycles, then goes to ACCESS.
- **ACCESS, write**
  - `dir_to_port = 1` and `to_port` = latched data for SETTLE cycles, then back to IDLE.
- **ACCESS, read**
  - `dir_to_port = 0` for SETTLE cycles.
  - `from_port` is registered on the last ACCESS cycle.
  - Then back to IDLE with `rsp_valid = 1` and `rsp_id` = latched `g` for exactly one cycle.
- `last_dir` updates on entry to ACCESS.
- Bus parking in IDLE: `dir_to_port` holds `last_dir` and `to_port` holds the last written value. After a write the bus stays driven; after a read it stays released.
- A single shared down-counter serves TURN and ACCESS. Its width is `$clog2(max(TURNAROUND, SETTLE)+1)`.
- Requests are not accepted outside IDLE. `req_valid` may rise or fall freely outside IDLE; only its level in IDLE matters.

## Timing
- Reset values: state IDLE, `rr = 0`, `last_dir = 0` (read).
- Outputs at reset: `req_ready` per IDLE rule, `rsp_valid = 0`, `rsp_id = 0`, `rsp_rdata = 0`, `dir_to_port = 0`, `to_port = 0`.
- Timeline, with the accept at cycle 0:
  - t = TURNAROUND if a turn is inserted, else 0.
  - ACCESS occupies cycles 1+t through SETTLE+t.
  - IDLE re-entered at cycle SETTLE+t+1. The next accept may occur there.
  - Read `rsp_valid` is high in cycle SETTLE+t+1, which is the same cycle a new accept may happen.
- Throughput with no direction change is one transfer per SETTLE+1 cycles.
- Simultaneous valid from both requesters: `rr` decides. Alternating grants are guaranteed under constant contention.
- Reset asserted mid-transaction:
  - `dir_to_port` drops to 0 asynchronously.
  - The in-flight transfer is discarded with no `rsp_valid`.
  - `last_dir` returns to read.
- `dir_to_port` never goes 1 in the cycle after a read ACCESS cycle unless `TURNAROUND == 0`.

## Structure
- `pocket_pkg` gains `port_seq_state_e` (IDLE, TURN, ACCESS) and the `PORT_DIR_READ` / `PORT_DIR_WRITE` constants.
- One sub-module, `rr_arbiter2`:
  - Inputs: `valid[1:0]`, `rr`.
  - Outputs: `grant_onehot[1:0]`, `grant_idx`.
  - Purely combinational; `rr` lives in the parent.
- All other logic (FSM, counter, latches, response register) lives in `port_sequencer`.

## Test plan
All scenarios use WIDTH=8, TURNAROUND=2, SETTLE=3.
- **First write after reset:** req0 write 0xA5 accepted at cycle 0 → `dir_to_port = 0` in cycles 1–2; `dir_to_port = 1` with `to_port = 0xA5` in cycles 3–5; IDLE at cycle 6 with the bus still driving 0xA5.
- **Back-to-back writes:** req0 0x11 then req0 0x22 → no TURN on the second; 0x22 appears exactly 4 cycles after 0x11 first appeared.
- **Write then read:** req1 read with `from_port = 0x3C` → 2 released cycles plus 3 ACCESS cycles; `rsp_valid` pulses once with `rsp_id = 1` and `rsp_rdata = 0x3C`.
- **Contention:** both requesters hold valid reads for 4 transactions → grants 0, 1, 0, 1; each `req_ready` is a single-cycle pulse; 4 `rsp_valid` pulses with matching ids.
- **Reset mid-drive:** `reset_n` low in ACCESS write cycle 2 → `dir_to_port = 0` the same cycle; no `rsp_valid`; after release, a write incurs TURN again.
- **Parameter corner:** TURNAROUND=0, SETTLE=1, alternating read/write → a transfer every 2 cycles with no TURN state visited.
